// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared constants and helpers for the pipelined immediate extender.
//   - MODE_* : 3-bit extension mode encodings (5..7 are illegal)
//   - IMM_IN_W / ERR_CNT_W / ROT_W : field widths
//   - mode_oh_t / decode_mode() : one-hot pre-decode of the mode field
// ---------------------------------------------------------------------------
package imm_pkg;

    localparam int IMM_IN_W  = 24;
    localparam int ERR_CNT_W = 8;
    localparam int MODE_W    = 3;
    localparam int ROT_W     = 4;

    localparam logic [MODE_W-1:0] MODE_ZX8  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ZX12 = 3'd1;
    localparam logic [MODE_W-1:0] MODE_BR   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ROT  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_SX12 = 3'd4;

    typedef struct packed {
        logic ill;
        logic sx12;
        logic rot;
        logic br;
        logic zx12;
        logic zx8;
    } mode_oh_t;

    function automatic mode_oh_t decode_mode(input logic [MODE_W-1:0] mode);
        mode_oh_t oh;
        oh = '0;
        case (mode)
            MODE_ZX8:  oh.zx8  = 1'b1;
            MODE_ZX12: oh.zx12 = 1'b1;
            MODE_BR:   oh.br   = 1'b1;
            MODE_ROT:  oh.rot  = 1'b1;
            MODE_SX12: oh.sx12 = 1'b1;
            default:   oh.ill  = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/imm_rotator.sv
// ---------------------------------------------------------------------------
// imm_rotator
// Combinational rotate-right of a DATA_W-bit word by 2*rot_i bit positions.
//   data_i : word to rotate
//   rot_i  : rotate amount in units of two bits
//   data_o : rotated word
// ---------------------------------------------------------------------------
module imm_rotator
    import imm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [ROT_W-1:0]  rot_i,
    output logic [DATA_W-1:0] data_o
);

    logic [ROT_W:0] sh;

    assign sh = {rot_i, 1'b0};

    // A left shift by DATA_W yields zero, so sh == 0 degenerates to data_i.
    always_comb begin
        data_o = (data_i >> sh) | (data_i << (DATA_W - int'(sh)));
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
// Two-stage valid/ready immediate generator for the decode stage.
//   S1 captures the raw immediate, tag, one-hot decoded mode and rotate
//   amount; S2 forms the DATA_W-bit operand and drives the outputs.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : input handshake (in_ready is combinational on
//                           out_ready and flush)
//   in_imm, in_mode,in_tag: raw 24-bit field, extension mode, sideband tag
//   flush                 : synchronous kill of both stages
//   out_valid/out_ready   : output handshake
//   out_imm,out_tag,out_err: extended operand, tag, illegal-mode flag
//   err_count             : saturating count of illegal beats entering S2
// ---------------------------------------------------------------------------
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHIFT_B = 2,
    parameter int TAG_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IMM_IN_W-1:0]  in_imm,
    input  logic [MODE_W-1:0]    in_mode,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // S1 state
    logic                 s1_v_q, s1_v_d;
    logic [IMM_IN_W-1:0]  s1_imm_q;
    logic [TAG_W-1:0]     s1_tag_q;
    mode_oh_t             s1_oh_q;
    logic [ROT_W-1:0]     s1_rot_q;

    // S2 state
    logic                 s2_v_q, s2_v_d;
    logic [DATA_W-1:0]    out_imm_q;
    logic [TAG_W-1:0]     out_tag_q;
    logic                 out_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Handshake
    logic s2_adv, s1_adv, accept, s1_move;

    assign s2_adv   = !s2_v_q || out_ready;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign in_ready = s1_adv && !flush;
    assign accept   = in_valid && in_ready;
    // A beat leaving S1 during a flush is killed, so it never reaches S2
    // and never counts as an error.
    assign s1_move  = s1_v_q && s2_adv && !flush;

    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else begin
            if (s1_adv) s1_v_d = accept;
            if (s2_adv) s2_v_d = s1_v_q;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s1_move && s1_oh_q.ill && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    // S2 datapath
    logic [DATA_W-1:0] br_ext, rot_in, rot_out, imm_res;

    assign br_ext = {{(DATA_W-IMM_IN_W){s1_imm_q[IMM_IN_W-1]}}, s1_imm_q};
    assign rot_in = {{(DATA_W-8){1'b0}}, s1_imm_q[7:0]};

    imm_rotator #(.DATA_W(DATA_W)) u_rot (
        .data_i (rot_in),
        .rot_i  (s1_rot_q),
        .data_o (rot_out)
    );

    always_comb begin
        imm_res = '0;
        if (s1_oh_q.zx8)
            imm_res = {{(DATA_W-8){1'b0}}, s1_imm_q[7:0]};
        else if (s1_oh_q.zx12)
            imm_res = {{(DATA_W-12){1'b0}}, s1_imm_q[11:0]};
        else if (s1_oh_q.br)
            imm_res = br_ext << SHIFT_B;
        else if (s1_oh_q.rot)
            imm_res = rot_out;
        else if (s1_oh_q.sx12)
            imm_res = {{(DATA_W-12){s1_imm_q[11]}}, s1_imm_q[11:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q    <= 1'b0;
            s1_imm_q  <= '0;
            s1_tag_q  <= '0;
            s1_oh_q   <= '0;
            s1_rot_q  <= '0;
            s2_v_q    <= 1'b0;
            out_imm_q <= '0;
            out_tag_q <= '0;
            out_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            err_cnt_q <= err_cnt_d;
            if (accept) begin
                s1_imm_q <= in_imm;
                s1_tag_q <= in_tag;
                s1_oh_q  <= decode_mode(in_mode);
                s1_rot_q <= in_imm[11:8];
            end
            if (s1_move) begin
                out_imm_q <= imm_res;
                out_tag_q <= s1_tag_q;
                out_err_q <= s1_oh_q.ill;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe at DATA_W=32, SHIFT_B=2, TAG_W=5.
module tb_imm_extend_pipe;
    import imm_pkg::*;

    localparam int DATA_W  = 32;
    localparam int SHIFT_B = 2;
    localparam int TAG_W   = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [23:0]       in_imm;
    logic [2:0]        in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;
    logic [7:0]        err_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.DATA_W(DATA_W), .SHIFT_B(SHIFT_B), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .err_count (err_count)
    );

    task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tg, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic [23:0] imm, input logic [TAG_W-1:0] t);
        in_mode = m;
        in_imm  = imm;
        in_tag  = t;
    endtask

    // One beat through an idle pipe; checks the two-edge latency and result.
    task automatic send_one(input string tg, input logic [2:0] m, input logic [23:0] imm,
                            input logic [TAG_W-1:0] t, input logic [31:0] exp, input logic exp_err);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(m, imm, t);
        #1;
        chk({tg, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tg, "_lat1"}, out_valid, 0);
        tick();
        chk({tg, "_vld"}, out_valid, 1);
        chk({tg, "_imm"}, out_imm, exp);
        chk({tg, "_tag"}, out_tag, t);
        chk({tg, "_err"}, out_err, exp_err);
    endtask

    task automatic stream_ill(input int n);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(3'd5, 24'h0, 5'd0);
        repeat (n) tick();
        in_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        logic acc;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_vld", out_valid, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_err", out_err, 0);
        chk("rst_cnt", err_count, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("rst_rdy", in_ready, 1);

        // basic modes
        send_one("zx8",  MODE_ZX8,  24'hABCDEF, 5'd1, 32'h000000EF, 1'b0);
        send_one("zx12", MODE_ZX12, 24'hABCDEF, 5'd2, 32'h00000DEF, 1'b0);
        send_one("sx12", MODE_SX12, 24'hABCDEF, 5'd3, 32'hFFFFFDEF, 1'b0);
        send_one("br_m2",  MODE_BR, 24'hFFFFFE, 5'd4, 32'hFFFFFFF8, 1'b0);
        send_one("br_p16", MODE_BR, 24'h000010, 5'd5, 32'h00000040, 1'b0);
        send_one("br_min", MODE_BR, 24'h800000, 5'd6, 32'hFE000000, 1'b0);
        send_one("rot8",   MODE_ROT, 24'h0004FF, 5'd7, 32'hFF000000, 1'b0);
        send_one("rot2",   MODE_ROT, 24'h000102, 5'd8, 32'h80000000, 1'b0);
        send_one("rot0",   MODE_ROT, 24'h0000A5, 5'd9, 32'h000000A5, 1'b0);
        send_one("ill6",   3'd6,     24'h123456, 5'd10, 32'h0, 1'b1);
        chk("ill6_cnt", err_count, 1);

        // back-pressure: tags 1..4, out_ready low
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(MODE_ZX8, 24'd17, 5'd1);
        #1 chk("bp_rdy1", in_ready, 1);
        tick();
        drive(MODE_ZX8, 24'd34, 5'd2);
        #1 chk("bp_rdy2", in_ready, 1);
        tick();
        drive(MODE_ZX8, 24'd51, 5'd3);
        nxt = 3;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_full", in_ready, 0);
            chk("bp_hold_vld", out_valid, 1);
            chk("bp_hold_tag", out_tag, 1);
            chk("bp_hold_imm", out_imm, 17);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("bp_vld", out_valid, 1);
            chk("bp_ord", out_tag, k);
            chk("bp_imm", out_imm, k * 17);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                if (nxt == 4) in_valid = 1'b0;
                else begin
                    nxt++;
                    drive(MODE_ZX8, 24'(nxt * 17), 5'(nxt));
                end
            end
        end
        chk("bp_drain", out_valid, 0);

        // flush with both stages full; S1 holds an illegal beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(MODE_ZX12, 24'h000555, 5'd5);
        tick();
        drive(3'd7, 24'h0, 5'd6);
        tick();
        drive(MODE_ZX8, 24'h000077, 5'd7);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("fl_rdy", in_ready, 0);
        chk("fl_hs_vld", out_valid, 1);
        chk("fl_hs_tag", out_tag, 5);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_vld", out_valid, 0);
        chk("fl_cnt", err_count, 1);
        tick();
        tick();
        chk("fl_drop", out_valid, 0);
        send_one("fl_next", MODE_ZX8, 24'h000042, 5'd8, 32'h00000042, 1'b0);
        tick();

        // saturating error counter
        stream_ill(253);
        chk("sat_254", err_count, 254);
        stream_ill(1);
        chk("sat_255", err_count, 255);
        stream_ill(46);
        chk("sat_hold", err_count, 255);

        // reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(MODE_ZX8, 24'h000099, 5'd9);
        tick();
        drive(MODE_ZX8, 24'h0000AA, 5'd10);
        tick();
        in_valid = 1'b0;
        chk("mid_vld", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mr_vld", out_valid, 0);
        chk("mr_imm", out_imm, 0);
        chk("mr_tag", out_tag, 0);
        chk("mr_err", out_err, 0);
        chk("mr_cnt", err_count, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mr_stale", out_valid, 0);
        end
        chk("mr_rdy", in_ready, 1);
        send_one("mr_next", MODE_ZX12, 24'h000ABC, 5'd11, 32'h00000ABC, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
